// File: rtl/pc_queue.sv
// ============================================================================
// Module   : pc_queue
// Brief    : Two-entry PC front/back queue with sequential, delayed-branch and
//            redirect updates, plus a circular history of retired front PCs.
//            Optional macro PC_QUEUE_ALIGN_CHECK_EN enables branch-target
//            alignment checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_queue #(
  parameter int unsigned       WIDTH       = 32,
  parameter int unsigned       STEP        = 4,
  parameter logic [WIDTH-1:0]  RESET_FRONT = '0,
  parameter logic [WIDTH-1:0]  RESET_BACK  = WIDTH'(4),
  parameter int unsigned       HIST_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              LE,
  input  logic                              branch_taken,
  input  logic [WIDTH-1:0]                  branch_target,
  input  logic                              redirect,
  input  logic [WIDTH-1:0]                  redirect_front,
  input  logic [WIDTH-1:0]                  redirect_back,
  input  logic [$clog2(HIST_DEPTH)-1:0]     hist_rd_idx,
  output logic [WIDTH-1:0]                  pc_front_out,
  output logic [WIDTH-1:0]                  pc_back_out,
  output logic                              pc_valid,
  output logic [WIDTH-1:0]                  hist_pc_out,
  output logic [$clog2(HIST_DEPTH+1)-1:0]   hist_count,
  output logic                              misalign_err
);

  localparam int unsigned c_PW = $clog2(HIST_DEPTH);
  localparam int unsigned c_CW = $clog2(HIST_DEPTH + 1);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_front, r_back;
  logic [WIDTH-1:0] w_front_nxt, w_back_nxt;
  logic             w_push;
  logic [WIDTH-1:0] w_target_ld;

  logic [WIDTH-1:0] r_hist [HIST_DEPTH];
  logic [c_PW-1:0]  r_wptr;
  logic [c_CW-1:0]  r_count;

`ifdef PC_QUEUE_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] c_ALIGN_MASK = WIDTH'(STEP - 1);

  logic r_misalign;
  logic w_branch_upd;

  assign w_target_ld  = branch_target & ~c_ALIGN_MASK;
  assign w_branch_upd = (r_state == RUN) && !redirect && LE && branch_taken;

  // Sticky until reset: only the reset branch ever clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_misalign <= 1'b0;
    else if (w_branch_upd && (|(branch_target & c_ALIGN_MASK)))
      r_misalign <= 1'b1;
  end

  assign misalign_err = r_misalign;
`else
  assign w_target_ld  = branch_target;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_front_nxt = r_front;
    w_back_nxt  = r_back;
    w_push      = 1'b0;
    case (r_state)
      BOOT, BUBBLE: begin
        // LE and branch_taken are ignored here; only a redirect reloads.
        if (redirect) begin
          w_front_nxt = redirect_front;
          w_back_nxt  = redirect_back;
          w_state_nxt = BUBBLE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (redirect) begin
          w_front_nxt = redirect_front;
          w_back_nxt  = redirect_back;
          w_state_nxt = BUBBLE;
        end else if (LE && branch_taken) begin
          w_front_nxt = r_back;
          w_back_nxt  = w_target_ld;
          w_push      = 1'b1;
        end else if (LE) begin
          w_front_nxt = r_back;
          w_back_nxt  = r_back + WIDTH'(STEP);
          w_push      = 1'b1;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BOOT;
      r_front <= RESET_FRONT;
      r_back  <= RESET_BACK;
    end else begin
      r_state <= w_state_nxt;
      r_front <= w_front_nxt;
      r_back  <= w_back_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < HIST_DEPTH; i++)
        r_hist[i] <= '0;
    end else if (w_push) begin
      r_hist[r_wptr] <= r_front;
      r_wptr         <= (r_wptr == c_PW'(HIST_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (r_count != c_CW'(HIST_DEPTH))
        r_count <= r_count + 1'b1;
    end
  end

  // Offset by HIST_DEPTH before subtracting so the modulo never goes negative.
  logic [c_PW:0]   w_rd_sum;
  logic [c_PW-1:0] w_rd_ptr;
  logic            w_rd_valid;

  assign w_rd_valid = (c_CW'(hist_rd_idx) < r_count);
  assign w_rd_sum   = (c_PW+1)'(r_wptr) + (c_PW+1)'(HIST_DEPTH - 1)
                    - (c_PW+1)'(hist_rd_idx);
  assign w_rd_ptr   = (w_rd_sum >= (c_PW+1)'(HIST_DEPTH))
                    ? c_PW'(w_rd_sum - (c_PW+1)'(HIST_DEPTH))
                    : c_PW'(w_rd_sum);

  assign hist_pc_out  = w_rd_valid ? r_hist[w_rd_ptr] : '0;
  assign hist_count   = r_count;
  assign pc_front_out = r_front;
  assign pc_back_out  = r_back;
  assign pc_valid     = (r_state == RUN);

endmodule

`default_nettype wire
